// File: rtl/vga_sync_receiver.sv
// VGA receive side: rebuilds pixel coordinates from hsync/vsync edges,
// re-times RGB and qualifies line/frame lengths into a lock flag.
module vga_sync_receiver #(
   parameter int HPIXELS     = 640,
   parameter int HFP         = 16,
   parameter int HSPULSE     = 96,
   parameter int HBP         = 48,
   parameter int VPIXELS     = 480,
   parameter int VFP         = 10,
   parameter int VSPULSE     = 2,
   parameter int VBP         = 33,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       vgaclk,
   input  logic       rst,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic [3:0] red_in,
   input  logic [3:0] green_in,
   input  logic [3:0] blue_in,
   output logic [9:0] rx_hc,
   output logic [9:0] rx_vc,
   output logic [3:0] rx_red,
   output logic [3:0] rx_green,
   output logic [3:0] rx_blue,
   output logic       pixel_valid,
   output logic       frame_start,
   output logic       locked,
   output logic [7:0] sync_err_cnt
);

   localparam int H_TOTAL = HPIXELS + HFP + HSPULSE + HBP;
   localparam int V_TOTAL = VPIXELS + VFP + VSPULSE + VBP;
   localparam int HLW     = $clog2(2 * H_TOTAL + 1);
   localparam int VLW     = $clog2(V_TOTAL + 1) + 1;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_LOAD = 10'(HPIXELS + HFP);
   localparam logic [9:0] V_LOAD = 10'(VPIXELS + VFP);
   localparam logic [9:0] H_ACT  = 10'(HPIXELS);
   localparam logic [9:0] V_ACT  = 10'(VPIXELS);

   localparam logic [HLW-1:0] HLEN_OK  = HLW'(H_TOTAL - 1);
   localparam logic [HLW-1:0] HLEN_TO  = HLW'(2 * H_TOTAL - 1);
   localparam logic [HLW-1:0] HLEN_MAX = HLW'(2 * H_TOTAL);
   localparam logic [VLW-1:0] VLEN_OK  = VLW'(V_TOTAL);
   localparam logic [7:0]     GOOD_MAX = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      SEARCH,
      ACQUIRE,
      LOCKED
   } state_t;

   state_t         state, state_next;
   logic           hs_q, vs_q;
   logic           hfall, vfall, h_wrap;
   logic [9:0]     hc_next, vc_next;
   logic [HLW-1:0] h_len, h_len_next;
   logic [VLW-1:0] v_len, v_len_next;
   logic           h_err, v_err, t_err, any_err;
   logic           skip_h, skip_v, skip_h_next, skip_v_next;
   logic           err_seen, err_seen_next;
   logic [7:0]     good_cnt, good_next, good_inc;
   logic [7:0]     err_cnt_next;
   logic           locked_next, pv_next, fs_next;

   // Coordinate recovery and length measurement
   always_comb begin
      hfall  = hs_q & ~hsync_in;
      vfall  = vs_q & ~vsync_in;
      h_wrap = (rx_hc == H_LAST) & ~hfall;

      hc_next = h_wrap ? '0 : rx_hc + 10'd1;
      if (hfall)
         hc_next = H_LOAD;

      vc_next = rx_vc;
      if (h_wrap)
         vc_next = (rx_vc == V_LAST) ? '0 : rx_vc + 10'd1;
      if (vfall)
         vc_next = V_LOAD;

      h_len_next = h_len;
      if (hfall)
         h_len_next = '0;
      else if (h_len != HLEN_MAX)
         h_len_next = h_len + HLW'(1);

      v_len_next = v_len;
      if (vfall)
         v_len_next = '0;
      else if (hfall && v_len != '1)
         v_len_next = v_len + VLW'(1);

      h_err = hfall & (h_len != HLEN_OK);
      v_err = vfall & (v_len != VLEN_OK);
      t_err = ~hfall & (h_len == HLEN_TO);
   end

   always_comb begin
      state_next    = state;
      good_next     = good_cnt;
      err_seen_next = err_seen;
      skip_h_next   = skip_h;
      skip_v_next   = skip_v;
      err_cnt_next  = sync_err_cnt;
      good_inc      = good_cnt + 8'd1;
      any_err       = 1'b0;

      unique case (state)
         SEARCH: begin
            if (vfall) begin
               state_next    = ACQUIRE;
               good_next     = '0;
               err_seen_next = 1'b0;
               skip_h_next   = 1'b1;
               skip_v_next   = 1'b1;
            end
         end
         ACQUIRE: begin
            if (hfall)
               skip_h_next = 1'b0;
            if (vfall)
               skip_v_next = 1'b0;
            any_err = (h_err & ~skip_h) | (v_err & ~skip_v) | t_err;
            if (t_err) begin
               state_next = SEARCH;
               good_next  = '0;
            end else if (any_err) begin
               // an error on the vfall itself closes that frame
               good_next     = '0;
               err_seen_next = ~vfall;
            end else if (vfall) begin
               err_seen_next = 1'b0;
               if (!err_seen) begin
                  good_next = good_inc;
                  if (good_inc >= GOOD_MAX)
                     state_next = LOCKED;
               end
            end
         end
         LOCKED: begin
            any_err = h_err | v_err | t_err;
            if (any_err) begin
               state_next = SEARCH;
               if (sync_err_cnt != 8'hFF)
                  err_cnt_next = sync_err_cnt + 8'd1;
            end
         end
         default: state_next = SEARCH;
      endcase

      locked_next = (state_next == LOCKED);
      pv_next     = locked_next & (hc_next < H_ACT) & (vc_next < V_ACT);
      fs_next     = locked_next & (hc_next == '0) & (vc_next == '0);
   end

   always_ff @(posedge vgaclk or negedge rst) begin
      if (!rst) begin
         state        <= SEARCH;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         h_len        <= '0;
         v_len        <= '0;
         skip_h       <= 1'b0;
         skip_v       <= 1'b0;
         err_seen     <= 1'b0;
         good_cnt     <= '0;
         rx_hc        <= '0;
         rx_vc        <= '0;
         rx_red       <= '0;
         rx_green     <= '0;
         rx_blue      <= '0;
         pixel_valid  <= 1'b0;
         frame_start  <= 1'b0;
         locked       <= 1'b0;
         sync_err_cnt <= '0;
      end else begin
         state        <= state_next;
         hs_q         <= hsync_in;
         vs_q         <= vsync_in;
         h_len        <= h_len_next;
         v_len        <= v_len_next;
         skip_h       <= skip_h_next;
         skip_v       <= skip_v_next;
         err_seen     <= err_seen_next;
         good_cnt     <= good_next;
         rx_hc        <= hc_next;
         rx_vc        <= vc_next;
         rx_red       <= pv_next ? red_in   : '0;
         rx_green     <= pv_next ? green_in : '0;
         rx_blue      <= pv_next ? blue_in  : '0;
         pixel_valid  <= pv_next;
         frame_start  <= fs_next;
         locked       <= locked_next;
         sync_err_cnt <= err_cnt_next;
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a shrunken 8x6 raster
// driven by a behavioural copy of the VGA timing generator.
module tb_vga_sync_receiver;

   localparam int HP = 4, HF = 1, HS = 2, HB = 1;
   localparam int VP = 2, VF = 1, VS = 1, VB = 2;
   localparam int HT = HP + HF + HS + HB;
   localparam int VT = VP + VF + VS + VB;
   localparam int FR = HT * VT;

   logic       vgaclk = 1'b0;
   logic       rst = 1'b1;
   logic       hsync_in = 1'b1, vsync_in = 1'b1;
   logic [3:0] red_in = '0, green_in = '0, blue_in = '0;
   logic [9:0] rx_hc, rx_vc;
   logic [3:0] rx_red, rx_green, rx_blue;
   logic       pixel_valid, frame_start, locked;
   logic [7:0] sync_err_cnt;

   int   total = 0, bad = 0;
   int   g_hc = 0, g_vc = 0, d_hc = 0, d_vc = 0, s_hc = 0, s_vc = 0;
   int   extra = 0, hold_h = 0, pv_n, fs_n, k;
   logic prev_vs = 1'b1, drv_vfall = 1'b0, s_vfall = 1'b0, pv_e;

   vga_sync_receiver #(
      .HPIXELS(HP), .HFP(HF), .HSPULSE(HS), .HBP(HB),
      .VPIXELS(VP), .VFP(VF), .VSPULSE(VS), .VBP(VB),
      .LOCK_FRAMES(2)
   ) dut (
      .vgaclk(vgaclk), .rst(rst),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .rx_hc(rx_hc), .rx_vc(rx_vc),
      .rx_red(rx_red), .rx_green(rx_green), .rx_blue(rx_blue),
      .pixel_valid(pixel_valid), .frame_start(frame_start),
      .locked(locked), .sync_err_cnt(sync_err_cnt)
   );

   always #5 vgaclk = ~vgaclk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic drive();
      logic hs, vs;
      hs = !(g_hc >= HP + HF && g_hc < HP + HF + HS);
      vs = !(g_vc >= VP + VF && g_vc < VP + VF + VS);
      if (hold_h > 0) begin
         hs = 1'b1;
         hold_h--;
      end
      drv_vfall = prev_vs & ~vs;
      prev_vs   = vs;
      hsync_in  = hs;
      vsync_in  = vs;
      red_in    = g_hc[3:0];
      green_in  = g_vc[3:0];
      blue_in   = 4'hC;
      d_hc      = g_hc;
      d_vc      = g_vc;
   endtask

   // s_* : what the DUT sampled on the edge just passed
   task automatic tick();
      @(posedge vgaclk);
      #1;
      s_hc    = d_hc;
      s_vc    = d_vc;
      s_vfall = drv_vfall;
      if (extra > 0) begin
         extra--;
      end else begin
         g_hc = (g_hc == HT - 1) ? 0 : g_hc + 1;
         if (g_hc == 0)
            g_vc = (g_vc == VT - 1) ? 0 : g_vc + 1;
      end
      drive();
   endtask

   task automatic relock(input string tag);
      int n;
      n = 0;
      for (int j = 0; j < 6 * FR && n < 3; j++) begin
         tick();
         if (s_vfall) begin
            n++;
            if (n == 2) chk({tag, "_prelock"}, locked, 0);
            if (n == 3) chk({tag, "_lock"}, locked, 1);
         end
      end
      if (n < 3) chk({tag, "_timeout"}, n, 3);
   endtask

   initial begin
      #1 rst = 1'b0;
      drive();
      repeat (3) @(posedge vgaclk);
      #1;
      chk("rst_hc", rx_hc, 0);
      chk("rst_vc", rx_vc, 0);
      chk("rst_lock", locked, 0);
      chk("rst_pv", pixel_valid, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_cnt", sync_err_cnt, 0);
      chk("rst_rgb", {rx_red, rx_green, rx_blue}, 0);
      rst = 1'b1;

      relock("t1");

      pv_n = 0;
      fs_n = 0;
      for (int j = 0; j < FR; j++) begin
         tick();
         pv_e = (s_hc < HP) && (s_vc < VP);
         chk("t2_hc", rx_hc, s_hc);
         chk("t2_vc", rx_vc, s_vc);
         chk("t2_pv", pixel_valid, pv_e);
         chk("t2_red", rx_red, pv_e ? s_hc[3:0] : 0);
         chk("t2_green", rx_green, pv_e ? s_vc[3:0] : 0);
         chk("t2_blue", rx_blue, pv_e ? 12 : 0);
         chk("t2_fs", frame_start, s_hc == 0 && s_vc == 0);
         pv_n += int'(pixel_valid);
         fs_n += int'(frame_start);
      end
      chk("t2_pv_count", pv_n, HP * VP);
      chk("t2_fs_count", fs_n, 1);

      while (!s_vfall) tick();
      extra = 1;
      repeat (2 * HT) tick();
      chk("t3_unlock", locked, 0);
      chk("t3_cnt", sync_err_cnt, 1);
      relock("t3");

      hold_h = 2 * HT + 4;
      repeat (2 * HT + 4) tick();
      k = 0;
      while (!(s_vc == 0 && s_hc == 1) && k < 2 * FR) begin
         tick();
         k++;
      end
      chk("t4_reach", k < 2 * FR, 1);
      chk("t4_unlock", locked, 0);
      chk("t4_pv", pixel_valid, 0);
      chk("t4_red", rx_red, 0);
      chk("t4_green", rx_green, 0);
      chk("t4_cnt", sync_err_cnt, 2);
      relock("t4");

      k = 0;
      while (!(s_vc == 1 && s_hc == 2) && k < 2 * FR) begin
         tick();
         k++;
      end
      chk("t5_pv_pre", pixel_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("t5_hc", rx_hc, 0);
      chk("t5_vc", rx_vc, 0);
      chk("t5_lock", locked, 0);
      chk("t5_pv", pixel_valid, 0);
      chk("t5_rgb", {rx_red, rx_green, rx_blue}, 0);
      chk("t5_cnt", sync_err_cnt, 0);
      repeat (3) tick();
      rst = 1'b1;
      relock("t5");

      for (int i = 1; i <= 260 && bad <= 20; i++) begin
         extra = 1;
         relock("t6");
         chk("t6_cnt", sync_err_cnt, (i < 255) ? i : 255);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
